// File: rtl/ppe_sync_param.sv
// rtl/ppe_sync_param.sv - clocked parametrised partial-sum processing element
module ppe_sync_param #(
    parameter int ADDR_W    = 4,
    parameter int OP_W      = 4,
    parameter int DATA_W    = 25,
    parameter int WEIGHT_W  = 8,
    parameter int FILTER_W  = 5,
    parameter int ROW_W     = 25,
    parameter int MY_ADDR   = 5,
    parameter int DEST_ADDR = 10,
    parameter int SKIP_ZERO = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ADDR_W+OP_W+DATA_W-1:0]   in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ADDR_W+OP_W+DATA_W-1:0]   out_data,
    output logic                            weights_loaded,
    output logic                            busy,
    output logic                            err
);
    localparam int PKT_W  = ADDR_W + OP_W + DATA_W;
    localparam int WPP    = DATA_W / WEIGHT_W;
    localparam int OUT_W  = ROW_W - FILTER_W + 1;
    localparam int IDX_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int PSUM_W = WEIGHT_W + $clog2(FILTER_W + 1);
    localparam int WPTR_W = $clog2(FILTER_W + WPP + 1);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(OUT_W - 1);
    localparam logic [OP_W-1:0]  OP_WGT  = OP_W'(0);
    localparam logic [OP_W-1:0]  OP_SPK  = OP_W'(1);
    localparam logic [OP_W-1:0]  OP_PSUM = OP_W'(2);
    localparam logic [OP_W-1:0]  OP_TS   = OP_W'(15);

    generate
        if (IDX_W + PSUM_W > DATA_W) begin : g_bad_fields
            $error("ppe_sync_param: window index and psum do not fit in the payload");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_TS} state_t;
    state_t state, state_nxt;

    logic [WEIGHT_W-1:0] w [FILTER_W];
    logic [ROW_W-1:0]    spike, cand_row;
    logic [FILTER_W-1:0] cand_win;
    logic [WPTR_W-1:0]   wptr, wbase, wnext;
    logic [IDX_W-1:0]    j, cand_idx;
    logic [PSUM_W-1:0]   cand_psum;
    logic [DATA_W-1:0]   win_payload;
    logic [PKT_W-1:0]    win_pkt;
    logic [ADDR_W-1:0]   addr;
    logic [OP_W-1:0]     op;
    logic accept, addr_ok, is_wgt, is_spk, is_ts;
    logic take, cand_skip, cand_last, done;

    // take: a candidate window is evaluated this cycle (emitted or skipped)
    always_comb begin
        addr      = in_data[PKT_W-1 -: ADDR_W];
        op        = in_data[DATA_W +: OP_W];
        accept    = in_valid && in_ready;
        addr_ok   = (addr == ADDR_W'(MY_ADDR));
        is_wgt    = accept && addr_ok && (op == OP_WGT);
        is_spk    = accept && addr_ok && (op == OP_SPK);
        is_ts     = accept && addr_ok && (op == OP_TS);
        take      = 1'b0;
        cand_idx  = j;
        case (state)
            S_IDLE: begin
                take     = is_spk && weights_loaded;
                cand_idx = '0;
            end
            S_COMPUTE: begin
                take     = !out_valid || (out_ready && (j != LAST));
                cand_idx = (out_valid && (j != LAST)) ? j + IDX_W'(1) : j;
            end
            default: ;
        endcase
        cand_row  = (state == S_IDLE) ? in_data[ROW_W-1:0] : spike;
        cand_win  = FILTER_W'(cand_row >> cand_idx);
        cand_last = (cand_idx == LAST);
        done      = (state == S_COMPUTE) && out_valid && out_ready && (j == LAST);
        wbase     = weights_loaded ? '0 : wptr;
        wnext     = wbase + WPTR_W'(WPP);
    end

    always_comb begin
        cand_psum = '0;
        for (int k = 0; k < FILTER_W; k++) begin
            if (cand_win[k]) cand_psum = cand_psum + PSUM_W'(w[k]);
        end
        cand_skip = (SKIP_ZERO != 0) && (cand_psum == '0);
        win_payload = '0;
        win_payload[DATA_W-1 -: IDX_W] = cand_idx;
        win_payload[PSUM_W-1:0]        = cand_psum;
        win_pkt = {ADDR_W'(DEST_ADDR), OP_PSUM, win_payload};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (take)       state_nxt = (cand_skip && cand_last) ? S_IDLE : S_COMPUTE;
                else if (is_ts) state_nxt = S_TS;
            end
            S_COMPUTE: if (done || (take && cand_skip && cand_last)) state_nxt = S_IDLE;
            S_TS:      if (out_valid && out_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == S_IDLE);
        busy     = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike          <= '0;
            wptr           <= '0;
            weights_loaded <= 1'b0;
            j              <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            err            <= 1'b0;
            for (int k = 0; k < FILTER_W; k++) w[k] <= '0;
        end else begin
            err <= accept && !(is_wgt || is_ts || take);
            if (is_wgt) begin
                for (int k = 0; k < FILTER_W; k++)
                    for (int s = 0; s < WPP; s++)
                        if (int'(wbase) + s == k) w[k] <= in_data[WEIGHT_W*s +: WEIGHT_W];
                if (wnext >= WPTR_W'(FILTER_W)) begin
                    wptr           <= '0;
                    weights_loaded <= 1'b1;
                end else begin
                    wptr           <= wnext;
                    weights_loaded <= 1'b0;
                end
            end
            if (take && (state == S_IDLE)) spike <= in_data[ROW_W-1:0];
            if (is_ts) begin
                out_valid <= 1'b1;
                out_data  <= {ADDR_W'(DEST_ADDR), OP_TS, DATA_W'(0)};
            end
            if (take) begin
                if (cand_skip) begin
                    out_valid <= 1'b0;
                    j         <= cand_idx + IDX_W'(1);
                end else begin
                    out_valid <= 1'b1;
                    out_data  <= win_pkt;
                    j         <= cand_idx;
                end
            end else if (done || ((state == S_TS) && out_valid && out_ready)) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ppe_sync_param.sv
// tb/tb_ppe_sync_param.sv - scoreboard bench for ppe_sync_param
module tb_ppe_sync_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [32:0] in_data = '0, out_data;
    logic        weights_loaded, busy, err;
    logic        in_valid2 = 1'b0, in_ready2, out_valid2;
    logic        out_ready2 = 1'b1;
    logic [32:0] in_data2 = '0, out_data2;
    logic        weights_loaded2, busy2, err2;

    ppe_sync_param u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .weights_loaded(weights_loaded), .busy(busy), .err(err)
    );

    ppe_sync_param #(.SKIP_ZERO(1)) u_dut_skip (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .weights_loaded(weights_loaded2), .busy(busy2), .err(err2)
    );

    int          ncmp = 0, nfail = 0, npop = 0, got2 = 0;
    logic        bp_en = 1'b0;
    logic [32:0] sb[$], sb2[$];
    logic        held_v = 1'b0;
    logic [32:0] held_d = '0;

    localparam logic [32:0] SPK_ODD  = {4'd5, 4'd1, 25'h0AAAAAA};
    localparam logic [32:0] SPK_EVEN = {4'd5, 4'd1, 25'h1555555};
    localparam logic [32:0] TS_IN    = {4'd5, 4'd15, 25'd0};
    localparam logic [32:0] TS_OUT   = {4'd10, 4'd15, 25'd0};

    function automatic logic [32:0] wpkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {4'd5, 4'd0, 1'b0, c, b, a};
    endfunction

    function automatic logic [32:0] win(input int j, input int ps);
        return {4'd10, 4'd2, 5'(j), 9'd0, 11'(ps)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (held_v) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(held_d));
            end
            if (out_valid) chk("in_ready_while_output", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_output", 64'(out_data), 64'h1_0000_0000_0);
                else chk("out_pkt", 64'(out_data), 64'(sb.pop_front()));
                npop++;
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            if (out_valid2 && out_ready2) begin
                got2++;
                if (sb2.size() == 0) chk("skip_unexpected", 64'(out_data2), 64'h1_0000_0000_0);
                else chk("skip_pkt", 64'(out_data2), 64'(sb2.pop_front()));
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic send(input int sel, input logic [32:0] p, output logic e);
        int n;
        n = 0;
        @(negedge clk);
        if (sel == 0) begin in_valid = 1'b1; in_data = p; end
        else begin in_valid2 = 1'b1; in_data2 = p; end
        while (((sel == 0) ? !in_ready : !in_ready2) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept_timeout", 64'(n < 300), 64'd1);
        @(posedge clk);
        #1;
        e = (sel == 0) ? err : err2;
        in_valid = 1'b0;
        in_valid2 = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (!(sb.size() == 0 && in_ready) && n < maxc) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 64'(n < maxc), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e;
        int   base, n;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_weights_loaded", 64'(weights_loaded), 64'd0);
        chk("rst_busy_err", 64'({busy, err}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        send(0, SPK_ODD, e);
        chk("err_spike_no_weights", 64'(e), 64'd1);
        @(posedge clk); #1;
        chk("err_is_pulse", 64'(err), 64'd0);
        chk("no_output_after_drop", 64'(out_valid), 64'd0);

        send(0, {4'd3, 4'd0, 25'd0}, e);
        chk("err_wrong_addr", 64'(e), 64'd1);
        send(0, {4'd5, 4'd7, 25'd0}, e);
        chk("err_bad_opcode", 64'(e), 64'd1);

        send(0, wpkt(8'd1, 8'd2, 8'd3), e);
        chk("wl_after_first", 64'({weights_loaded, e}), 64'd0);
        send(0, wpkt(8'd4, 8'd5, 8'd0), e);
        chk("wl_after_second", 64'({weights_loaded, e}), 64'd2);

        for (int j = 0; j < 21; j++) sb.push_back(win(j, (j % 2 == 0) ? 6 : 9));
        send(0, SPK_ODD, e);
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("latency_data", 64'(out_data), 64'(win(0, 6)));
        chk("busy_in_compute", 64'(busy), 64'd1);
        repeat (21) @(negedge clk);
        #1;
        chk("row_back_to_back", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
        chk("idle_after_row", 64'({in_ready, busy}), 64'd2);

        for (int j = 0; j < 21; j++) sb.push_back(win(j, (j % 2 == 0) ? 9 : 6));
        send(0, SPK_EVEN, e);
        drain(100);

        sb.push_back(TS_OUT);
        send(0, TS_IN, e);
        chk("ts_valid", 64'(out_valid), 64'd1);
        drain(50);
        chk("wl_after_ts", 64'(weights_loaded), 64'd1);
        for (int j = 0; j < 21; j++) sb.push_back(win(j, (j % 2 == 0) ? 6 : 9));
        send(0, SPK_ODD, e);
        drain(100);

        bp_en = 1'b1;
        for (int j = 0; j < 21; j++) sb.push_back(win(j, (j % 2 == 0) ? 9 : 6));
        send(0, SPK_EVEN, e);
        drain(600);
        bp_en = 1'b0;

        send(1, wpkt(8'd0, 8'd0, 8'd0), e);
        send(1, wpkt(8'd0, 8'd7, 8'd0), e);
        chk("skip_wl", 64'(weights_loaded2), 64'd1);
        sb2.push_back(win(6, 7));
        send(1, {4'd5, 4'd1, 25'd1 << 10}, e);
        repeat (40) @(negedge clk);
        chk("skip_one_packet", 64'(got2), 64'd1);
        chk("skip_queue_empty", 64'(sb2.size()), 64'd0);
        chk("skip_idle", 64'({in_ready2, out_valid2}), 64'd2);

        @(negedge clk);
        for (int j = 0; j < 21; j++) sb.push_back(win(j, (j % 2 == 0) ? 6 : 9));
        base = npop;
        send(0, SPK_ODD, e);
        n = 0;
        while (npop < base + 10 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reach_window_10", 64'(n < 200), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_weights", 64'(weights_loaded), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_quiet", 64'({out_valid, weights_loaded}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
